// File: rtl/vscale_mem_arbiter.sv
// Shares one AHB-lite master port between instruction and data requesters, one transfer at a time.
// Define VSCALE_MEM_ARB_RR_EN for round-robin arbitration; otherwise dmem has fixed priority.
module vscale_mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              reset,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wait,
  output logic [31:0]       imem_rdata,
  output logic              imem_err,
  input  logic              dmem_req,
  input  logic              dmem_wen,
  input  logic [2:0]        dmem_size,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic              dmem_wait,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t      state;
  logic        grant_dmem;
  logic        pick_dmem;
  logic        done;
  logic        done_imem;
  logic        done_dmem;
  logic [31:0] cap_data;
  logic [31:0] imem_rdata_q;
  logic [31:0] dmem_rdata_q;

`ifdef VSCALE_MEM_ARB_RR_EN
  logic last_dmem;

  // On contention, serve whichever port did not win the previous grant.
  always_comb pick_dmem = dmem_req & (~imem_req | ~last_dmem);

  always_ff @(posedge hclk) begin
    if (reset) begin
      last_dmem <= 1'b0;
    end else if (state == S_IDLE && (imem_req || dmem_req)) begin
      last_dmem <= pick_dmem;
    end
  end
`else
  always_comb pick_dmem = dmem_req;
`endif

  // Completion is combinational so the requester sees wait drop in the data-phase cycle itself.
  assign done      = ~reset & (state == S_DATA) & hready;
  assign done_imem = done & ~grant_dmem;
  assign done_dmem = done & grant_dmem;
  assign cap_data  = hresp ? 32'h0 : hrdata;

  assign imem_wait  = imem_req & ~done_imem;
  assign dmem_wait  = dmem_req & ~done_dmem;
  assign imem_err   = done_imem & hresp;
  assign dmem_err   = done_dmem & hresp;
  assign imem_rdata = done_imem ? cap_data : imem_rdata_q;
  assign dmem_rdata = done_dmem ? cap_data : dmem_rdata_q;
  assign hburst     = 3'b000;

  always_ff @(posedge hclk) begin
    if (reset) begin
      state        <= S_IDLE;
      grant_dmem   <= 1'b0;
      htrans       <= HTRANS_IDLE;
      haddr        <= '0;
      hwrite       <= 1'b0;
      hsize        <= 3'b000;
      hwdata       <= 32'h0;
      imem_rdata_q <= 32'h0;
      dmem_rdata_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (imem_req || dmem_req) begin
            state      <= S_ADDR;
            htrans     <= HTRANS_NONSEQ;
            grant_dmem <= pick_dmem;
            if (pick_dmem) begin
              haddr  <= dmem_addr;
              hwrite <= dmem_wen;
              hsize  <= dmem_size;
              hwdata <= dmem_wdata;
            end else begin
              haddr  <= imem_addr;
              hwrite <= 1'b0;
              hsize  <= HSIZE_WORD;
              hwdata <= 32'h0;
            end
          end
        end
        S_ADDR: begin
          if (hready) begin
            state  <= S_DATA;
            htrans <= HTRANS_IDLE;
          end
        end
        S_DATA: begin
          if (hready) begin
            state <= S_IDLE;
            if (grant_dmem) begin
              dmem_rdata_q <= cap_data;
            end else begin
              imem_rdata_q <= cap_data;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          htrans <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Self-checking bench for vscale_mem_arbiter; honours VSCALE_MEM_ARB_RR_EN for grant-order expectations.
module tb_vscale_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              hclk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_wait;
  logic [31:0]       imem_rdata;
  logic              imem_err;
  logic              dmem_req;
  logic              dmem_wen;
  logic [2:0]        dmem_size;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_wait;
  logic [31:0]       dmem_rdata;
  logic              dmem_err;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int   checks = 0;
  int   fails  = 0;

  vscale_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .hclk(hclk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // Inputs change just after the rising edge; outputs are observed on the falling edge.
  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic test_reset();
    sample();
    checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans got=%h exp=00", htrans); end
    checks++; if (haddr !== 32'h0) begin fails++; $display("FAIL rst_haddr got=%h exp=0", haddr); end
    checks++; if (hwrite !== 1'b0) begin fails++; $display("FAIL rst_hwrite got=%b exp=0", hwrite); end
    checks++; if (hsize !== 3'b000) begin fails++; $display("FAIL rst_hsize got=%b exp=000", hsize); end
    checks++; if (hwdata !== 32'h0) begin fails++; $display("FAIL rst_hwdata got=%h exp=0", hwdata); end
    checks++; if (hburst !== 3'b000) begin fails++; $display("FAIL rst_hburst got=%b exp=000", hburst); end
    checks++; if (imem_rdata !== 32'h0) begin fails++; $display("FAIL rst_imem_rdata got=%h exp=0", imem_rdata); end
    checks++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL rst_dmem_rdata got=%h exp=0", dmem_rdata); end
    checks++; if ({imem_err, dmem_err} !== 2'b00) begin fails++; $display("FAIL rst_err got=%b exp=00", {imem_err, dmem_err}); end
    checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL rst_imem_wait got=%b exp=1", imem_wait); end
    checks++; if (dmem_wait !== 1'b0) begin fails++; $display("FAIL rst_dmem_wait got=%b exp=0", dmem_wait); end
    next_cycle();
    reset = 1'b0;
    imem_req = 1'b0;
  endtask

  task automatic test_imem_read();
    exp_t e;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0000_0013;
    imem_addr = 32'h200; imem_req = 1'b1;
    e.rdata = 32'h0000_0013; e.err = 1'b0; iq.push_back(e);
    sample();
    checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL ird_c1_htrans got=%h exp=00", htrans); end
    checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL ird_c1_wait got=%b exp=1", imem_wait); end
    next_cycle(); sample();
    checks++; if (htrans !== 2'b10) begin fails++; $display("FAIL ird_c2_htrans got=%h exp=10", htrans); end
    checks++; if (haddr !== 32'h200) begin fails++; $display("FAIL ird_c2_haddr got=%h exp=200", haddr); end
    checks++; if (hwrite !== 1'b0) begin fails++; $display("FAIL ird_c2_hwrite got=%b exp=0", hwrite); end
    checks++; if (hsize !== 3'b010) begin fails++; $display("FAIL ird_c2_hsize got=%b exp=010", hsize); end
    checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL ird_c2_wait got=%b exp=1", imem_wait); end
    next_cycle(); sample();
    e = iq.pop_front();
    checks++; if (imem_wait !== 1'b0) begin fails++; $display("FAIL ird_c3_wait got=%b exp=0", imem_wait); end
    checks++; if (imem_rdata !== e.rdata) begin fails++; $display("FAIL ird_rdata got=%h exp=%h", imem_rdata, e.rdata); end
    checks++; if (imem_err !== e.err) begin fails++; $display("FAIL ird_err got=%b exp=%b", imem_err, e.err); end
    next_cycle();
    imem_req = 1'b0; hrdata = 32'hBAD0_BAD0;
    sample();
    checks++; if (imem_rdata !== 32'h0000_0013) begin fails++; $display("FAIL ird_hold got=%h exp=00000013", imem_rdata); end
    checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL ird_c4_htrans got=%h exp=00", htrans); end
    next_cycle();
  endtask

  task automatic test_dmem_write_wait();
    exp_t e;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h5A5A_0000;
    dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h1000;
    dmem_size = 3'b010; dmem_wdata = 32'hDEAD_BEEF;
    e.rdata = 32'h5A5A_0000; e.err = 1'b0; dq.push_back(e);
    sample();
    checks++; if (dmem_wait !== 1'b1) begin fails++; $display("FAIL dwr_c1_wait got=%b exp=1", dmem_wait); end
    next_cycle(); sample();
    checks++; if (htrans !== 2'b10) begin fails++; $display("FAIL dwr_c2_htrans got=%h exp=10", htrans); end
    checks++; if (hwrite !== 1'b1) begin fails++; $display("FAIL dwr_c2_hwrite got=%b exp=1", hwrite); end
    checks++; if (haddr !== 32'h1000) begin fails++; $display("FAIL dwr_c2_haddr got=%h exp=1000", haddr); end
    checks++; if (hsize !== 3'b010) begin fails++; $display("FAIL dwr_c2_hsize got=%b exp=010", hsize); end
    for (int c = 3; c <= 5; c++) begin
      next_cycle();
      hready = (c == 5);
      sample();
      checks++; if (hwdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL dwr_c%0d_hwdata got=%h exp=deadbeef", c, hwdata); end
      checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL dwr_c%0d_htrans got=%h exp=00", c, htrans); end
      checks++; if (dmem_wait !== (c != 5)) begin fails++; $display("FAIL dwr_c%0d_wait got=%b exp=%b", c, dmem_wait, c != 5); end
    end
    e = dq.pop_front();
    checks++; if (dmem_rdata !== e.rdata) begin fails++; $display("FAIL dwr_rdata got=%h exp=%h", dmem_rdata, e.rdata); end
    checks++; if (dmem_err !== e.err) begin fails++; $display("FAIL dwr_err got=%b exp=%b", dmem_err, e.err); end
    next_cycle();
    dmem_req = 1'b0; dmem_wen = 1'b0;
    next_cycle();
  endtask

  task automatic test_req_drop();
    exp_t e;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h1111_1111;
    imem_addr = 32'h400; imem_req = 1'b1;
    e.rdata = 32'h1111_1111; e.err = 1'b0; iq.push_back(e);
    sample();
    checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL drp_c1_wait got=%b exp=1", imem_wait); end
    next_cycle();
    imem_req = 1'b0; dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h800; dmem_size = 3'b010;
    e.rdata = 32'h2222_2222; e.err = 1'b0; dq.push_back(e);
    sample();
    checks++; if (haddr !== 32'h400) begin fails++; $display("FAIL drp_c2_haddr got=%h exp=400", haddr); end
    checks++; if (htrans !== 2'b10) begin fails++; $display("FAIL drp_c2_htrans got=%h exp=10", htrans); end
    checks++; if (dmem_wait !== 1'b1) begin fails++; $display("FAIL drp_c2_dwait got=%b exp=1", dmem_wait); end
    next_cycle(); sample();
    e = iq.pop_front();
    checks++; if (imem_rdata !== e.rdata) begin fails++; $display("FAIL drp_irdata got=%h exp=%h", imem_rdata, e.rdata); end
    checks++; if (dmem_wait !== 1'b1) begin fails++; $display("FAIL drp_c3_dwait got=%b exp=1", dmem_wait); end
    next_cycle();
    hrdata = 32'h2222_2222;
    sample();
    checks++; if (imem_rdata !== 32'h1111_1111) begin fails++; $display("FAIL drp_ihold got=%h exp=11111111", imem_rdata); end
    checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL drp_c4_htrans got=%h exp=00", htrans); end
    next_cycle(); sample();
    checks++; if (haddr !== 32'h800) begin fails++; $display("FAIL drp_c5_haddr got=%h exp=800", haddr); end
    next_cycle(); sample();
    e = dq.pop_front();
    checks++; if (dmem_wait !== 1'b0) begin fails++; $display("FAIL drp_c6_dwait got=%b exp=0", dmem_wait); end
    checks++; if (dmem_rdata !== e.rdata) begin fails++; $display("FAIL drp_drdata got=%h exp=%h", dmem_rdata, e.rdata); end
    next_cycle();
    dmem_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_error();
    exp_t e;
    int   lat;
    lat = 0;
    hresp = 1'b1; hrdata = 32'hFFFF_1234;
    dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h44; dmem_size = 3'b000;
    e.rdata = 32'h0; e.err = 1'b1; dq.push_back(e);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      hready = (c != 2);
      sample();
      if (!dmem_wait) lat = c;
      else next_cycle();
    end
    checks++; if (lat !== 4) begin fails++; $display("FAIL err_latency got=%0d exp=4", lat); end
    e = dq.pop_front();
    checks++; if (dmem_err !== e.err) begin fails++; $display("FAIL err_pulse got=%b exp=%b", dmem_err, e.err); end
    checks++; if (dmem_rdata !== e.rdata) begin fails++; $display("FAIL err_rdata got=%h exp=%h", dmem_rdata, e.rdata); end
    next_cycle();
    dmem_req = 1'b0; hresp = 1'b0;
    sample();
    checks++; if (dmem_err !== 1'b0) begin fails++; $display("FAIL err_pulse_end got=%b exp=0", dmem_err); end
    checks++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL err_rdata_hold got=%h exp=0", dmem_rdata); end
    next_cycle();
    hrdata = 32'h1234_5678; dmem_req = 1'b1; dmem_addr = 32'h48; dmem_size = 3'b010;
    e.rdata = 32'h1234_5678; e.err = 1'b0; dq.push_back(e);
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      sample();
      if (!dmem_wait) lat = c;
      else next_cycle();
    end
    e = dq.pop_front();
    checks++; if (lat !== 3) begin fails++; $display("FAIL err_next_latency got=%0d exp=3", lat); end
    checks++; if (dmem_rdata !== e.rdata) begin fails++; $display("FAIL err_next_rdata got=%h exp=%h", dmem_rdata, e.rdata); end
    checks++; if (dmem_err !== e.err) begin fails++; $display("FAIL err_next_err got=%b exp=%b", dmem_err, e.err); end
    next_cycle();
    dmem_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hAAAA_AAAA;
    imem_addr = 32'h204; imem_req = 1'b1;
    next_cycle(); next_cycle();
    reset = 1'b1; hready = 1'b0;
    sample();
    checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL rmid_wait got=%b exp=1", imem_wait); end
    next_cycle();
    reset = 1'b0; imem_req = 1'b0; hready = 1'b1;
    sample();
    checks++; if (htrans !== 2'b00) begin fails++; $display("FAIL rmid_htrans got=%h exp=00", htrans); end
    checks++; if (imem_rdata !== 32'h0) begin fails++; $display("FAIL rmid_irdata got=%h exp=0", imem_rdata); end
    checks++; if (dmem_rdata !== 32'h0) begin fails++; $display("FAIL rmid_drdata got=%h exp=0", dmem_rdata); end
    checks++; if ({imem_err, dmem_err} !== 2'b00) begin fails++; $display("FAIL rmid_err got=%b exp=00", {imem_err, dmem_err}); end
    next_cycle();
    imem_addr = 32'h300; imem_req = 1'b1; hrdata = 32'h0000_0099;
    e.rdata = 32'h0000_0099; e.err = 1'b0; iq.push_back(e);
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      sample();
      if (!imem_wait) lat = c;
      else next_cycle();
    end
    e = iq.pop_front();
    checks++; if (lat !== 3) begin fails++; $display("FAIL rmid_latency got=%0d exp=3", lat); end
    checks++; if (imem_rdata !== e.rdata) begin fails++; $display("FAIL rmid_rdata got=%h exp=%h", imem_rdata, e.rdata); end
    next_cycle();
    imem_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    byte gq[$];
    byte exp_g;
    byte got_g;
    int  ndone;
    int  last_c;
    ndone = 0; last_c = 0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
`ifdef VSCALE_MEM_ARB_RR_EN
    gq = '{"D", "I", "D", "I"};
`else
    gq = '{"D", "D", "D", "D"};
`endif
    hready = 1'b1; hresp = 1'b0; hrdata = 32'hC0DE_0000;
    imem_addr = 32'h500; dmem_addr = 32'h900; dmem_wen = 1'b0; dmem_size = 3'b010;
    imem_req = 1'b1; dmem_req = 1'b1;
    for (int c = 1; c <= 30 && ndone < 4; c++) begin
      sample();
`ifndef VSCALE_MEM_ARB_RR_EN
      checks++; if (imem_wait !== 1'b1) begin fails++; $display("FAIL b2b_imem_wait c=%0d got=%b exp=1", c, imem_wait); end
`endif
      got_g = 8'h0;
      if (!dmem_wait) got_g = "D";
      else if (!imem_wait) got_g = "I";
      if (got_g != 8'h0) begin
        exp_g = gq.pop_front();
        checks++; if (got_g !== exp_g) begin fails++; $display("FAIL b2b_grant%0d got=%s exp=%s", ndone, got_g, exp_g); end
        if (ndone > 0) begin
          checks++; if (c - last_c !== 3) begin fails++; $display("FAIL b2b_spacing got=%0d exp=3", c - last_c); end
        end
        last_c = c;
        ndone++;
      end
      if (ndone < 4) next_cycle();
    end
    checks++; if (ndone !== 4) begin fails++; $display("FAIL b2b_count got=%0d exp=4", ndone); end
    next_cycle();
    imem_req = 1'b0; dmem_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    imem_req = 1'b1; imem_addr = '0;
    dmem_req = 1'b0; dmem_wen = 1'b0; dmem_size = 3'b000; dmem_addr = '0; dmem_wdata = 32'h0;
    hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    repeat (3) next_cycle();
    test_reset();
    test_imem_read();
    test_dmem_write_wait();
    test_req_drop();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
